// File: rtl/microwave_pkg.sv
// Shared types and constants for the microwave keypad/cook sequencer.
package microwave_pkg;

  typedef enum logic [1:0] {
    S_IDLE,
    S_COOK,
    S_PAUSE,
    S_DONE
  } mw_state_t;

  typedef logic [3:0] bcd_t;

  localparam logic [15:0] BCD_ZERO            = 16'h0000;
  localparam logic [15:0] QUICK_START_DEFAULT = 16'h0030;

endpackage

// File: rtl/bcd_mmss_dec.sv
// One-second BCD decrement of an MM:SS value; seconds above 59 count down linearly.
module bcd_mmss_dec
  import microwave_pkg::*;
(
  input  logic [15:0] time_in,
  output logic [15:0] time_out,
  output logic        zero_next
);

  bcd_t min_t, min_u, sec_t, sec_u;

  always_comb begin
    {min_t, min_u, sec_t, sec_u} = time_in;
    if (sec_u != 4'd0) begin
      sec_u = sec_u - 4'd1;
    end else begin
      sec_u = 4'd9;
      if (sec_t != 4'd0) begin
        sec_t = sec_t - 4'd1;
      end else begin
        // Borrow from the minutes field; the caller never decrements 00:00.
        sec_t = 4'd5;
        if (min_u != 4'd0) begin
          min_u = min_u - 4'd1;
        end else begin
          min_u = 4'd9;
          min_t = min_t - 4'd1;
        end
      end
    end
    time_out  = {min_t, min_u, sec_t, sec_u};
    zero_next = (time_out == BCD_ZERO);
  end

endmodule

// File: rtl/microwave_controller.sv
// Keypad capture, MM:SS time register and cook state machine for the microwave panel.
module microwave_controller
  import microwave_pkg::*;
#(
  parameter logic [15:0] QUICK_START_BCD = QUICK_START_DEFAULT
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [3:0]  digit,
  input  logic        loadn,
  input  logic        startn,
  input  logic        stopn,
  input  logic        door_closed,
  input  logic        tick_1hz,
  output logic        enablen,
  output logic [15:0] time_bcd,
  output logic        mag_on,
  output logic        done
);

  // Bit order {door_closed, stopn, startn, loadn}; active-low keys idle high.
  localparam logic [3:0] SYNC_RESET = 4'b0111;

  logic [3:0]  raw, sync1, sync2, hist;
  logic        load_ev, start_ev, stop_ev, door_ok;
  mw_state_t   state, state_next;
  logic [15:0] time_q, time_next, time_dec;
  logic        dec_zero;

  assign raw = {door_closed, stopn, startn, loadn};

  always_ff @(posedge clk) begin
    if (reset) begin
      sync1 <= SYNC_RESET;
      sync2 <= SYNC_RESET;
      hist  <= SYNC_RESET;
    end else begin
      sync1 <= raw;
      sync2 <= sync1;
      hist  <= sync2;
    end
  end

  always_comb begin
    load_ev  = hist[0] & ~sync2[0];
    start_ev = hist[1] & ~sync2[1];
    stop_ev  = hist[2] & ~sync2[2];
    door_ok  = sync2[3];
  end

  bcd_mmss_dec u_dec (
    .time_in   (time_q),
    .time_out  (time_dec),
    .zero_next (dec_zero)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      state  <= S_IDLE;
      time_q <= BCD_ZERO;
    end else begin
      state  <= state_next;
      time_q <= time_next;
    end
  end

  always_comb begin
    state_next = state;
    time_next  = time_q;
    case (state)
      S_IDLE: begin
        // A start event always consumes the cycle, so a coincident key is dropped.
        if (stop_ev) begin
          time_next = BCD_ZERO;
        end else if (start_ev) begin
          if (door_ok) begin
            state_next = S_COOK;
            if (time_q == BCD_ZERO) time_next = QUICK_START_BCD;
          end
        end else if (load_ev && (digit <= 4'd9)) begin
          time_next = {time_q[11:0], digit};
        end
      end
      S_COOK: begin
        if (stop_ev || !door_ok) begin
          state_next = S_PAUSE;
        end else if (tick_1hz) begin
          time_next = time_dec;
          if (dec_zero) state_next = S_DONE;
        end
      end
      S_PAUSE: begin
        if (stop_ev) begin
          state_next = S_IDLE;
          time_next  = BCD_ZERO;
        end else if (door_ok && start_ev) begin
          state_next = S_COOK;
        end
      end
      S_DONE: begin
        if (stop_ev || !door_ok || start_ev) state_next = S_IDLE;
      end
      default: state_next = S_IDLE;
    endcase
  end

  // Magnetron is additionally gated by the synchronized door so it drops as soon as the door opens.
  always_comb begin
    enablen  = (state != S_IDLE);
    mag_on   = (state == S_COOK) && door_ok;
    done     = (state == S_DONE);
    time_bcd = time_q;
  end

endmodule

// File: tb/tb_microwave_controller.sv
// Self-checking bench: scripted panel sequences plus randomized stimulus against a reference model.
module tb_microwave_controller;

  logic        clk = 1'b0;
  logic        reset, loadn, startn, stopn, door_closed, tick_1hz;
  logic [3:0]  digit;
  logic        enablen, mag_on, done;
  logic [15:0] time_bcd;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  microwave_controller #(.QUICK_START_BCD(16'h0030)) dut (
    .clk         (clk),
    .reset       (reset),
    .digit       (digit),
    .loadn       (loadn),
    .startn      (startn),
    .stopn       (stopn),
    .door_closed (door_closed),
    .tick_1hz    (tick_1hz),
    .enablen     (enablen),
    .time_bcd    (time_bcd),
    .mag_on      (mag_on),
    .done        (done)
  );

  task automatic check(input string nm, input logic [15:0] act, input logic [15:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic cycles(input int n);
    repeat (n) @(negedge clk);
  endtask

  // ---------------- scripted operations ----------------
  localparam int OP_NONE  = 0;
  localparam int OP_KEY   = 1;
  localparam int OP_HOLD  = 2;
  localparam int OP_START = 3;
  localparam int OP_STOP  = 4;
  localparam int OP_BOTH  = 5;
  localparam int OP_TICK  = 6;
  localparam int OP_DOOR  = 7;
  localparam int OP_RESET = 8;

  typedef struct {
    int          op;
    int          arg;
    logic [15:0] t;
    logic        mag;
    logic        dn;
    logic        en;
  } vec_t;

  vec_t vecs[$];

  function automatic void add(input int op, input int arg, input logic [15:0] t,
                              input logic mag, input logic dn, input logic en);
    vec_t v;
    v.op = op; v.arg = arg; v.t = t; v.mag = mag; v.dn = dn; v.en = en;
    vecs.push_back(v);
  endfunction

  task automatic run_op(input int op, input int arg);
    case (op)
      OP_KEY:   begin digit = 4'(arg); loadn = 1'b0; cycles(3); loadn = 1'b1; cycles(3); end
      OP_HOLD:  begin digit = 4'(arg); loadn = 1'b0; cycles(20); loadn = 1'b1; cycles(3); end
      OP_START: begin startn = 1'b0; cycles(3); startn = 1'b1; cycles(3); end
      OP_STOP:  begin stopn = 1'b0; cycles(3); stopn = 1'b1; cycles(3); end
      OP_BOTH:  begin startn = 1'b0; stopn = 1'b0; cycles(3); startn = 1'b1; stopn = 1'b1; cycles(3); end
      OP_TICK:  repeat (arg) begin tick_1hz = 1'b1; cycles(1); tick_1hz = 1'b0; cycles(1); end
      OP_DOOR:  begin door_closed = arg[0]; cycles(3); end
      OP_RESET: begin reset = 1'b1; cycles(1); end
      default:  cycles(1);
    endcase
  endtask

  // ---------------- reference model ----------------
  typedef enum {M_IDLE, M_COOK, M_PAUSE, M_DONE} mstate_e;
  mstate_e     m_st;
  int          m_val;           // time as decimal MMSS, e.g. 99 means 00:99
  logic [3:0]  p1, p2, p3;      // samples from 1/2/3 edges ago {door,stop,start,load}
  logic        exp_mag;

  function automatic logic [15:0] to_bcd(input int v);
    return {4'(v / 1000), 4'((v / 100) % 10), 4'((v / 10) % 10), 4'(v % 10)};
  endfunction

  function automatic int dec_time(input int v);
    int mins, secs;
    mins = v / 100;
    secs = v % 100;
    if (secs > 0) secs--;
    else begin secs = 59; mins--; end
    return mins * 100 + secs;
  endfunction

  task automatic model_step(input logic rst, input logic [3:0] x, input logic tk, input logic [3:0] dg);
    logic ld, sg, sp, dok;
    if (rst) begin
      m_st = M_IDLE; m_val = 0;
      p1 = 4'b0111; p2 = 4'b0111; p3 = 4'b0111;
    end else begin
      ld  = p3[0] & ~p2[0];
      sg  = p3[1] & ~p2[1];
      sp  = p3[2] & ~p2[2];
      dok = p2[3];
      case (m_st)
        M_IDLE:
          if (sp) m_val = 0;
          else if (sg) begin
            if (dok) begin
              if (m_val == 0) m_val = 30;
              m_st = M_COOK;
            end
          end else if (ld && dg <= 4'd9) m_val = (m_val * 10 + int'(dg)) % 10000;
        M_COOK:
          if (sp || !dok) m_st = M_PAUSE;
          else if (tk) begin
            m_val = dec_time(m_val);
            if (m_val == 0) m_st = M_DONE;
          end
        M_PAUSE:
          if (sp) begin m_st = M_IDLE; m_val = 0; end
          else if (dok && sg) m_st = M_COOK;
        default:
          if (sp || !dok || sg) m_st = M_IDLE;
      endcase
      p3 = p2; p2 = p1; p1 = x;
    end
    exp_mag = (m_st == M_COOK) && p2[3];
  endtask

  // ---------------- test ----------------
  initial begin
    add(OP_NONE, 0, 16'h0000, 0, 0, 0);
    add(OP_KEY, 1, 16'h0001, 0, 0, 0);
    add(OP_KEY, 2, 16'h0012, 0, 0, 0);
    add(OP_KEY, 3, 16'h0123, 0, 0, 0);
    add(OP_KEY, 0, 16'h1230, 0, 0, 0);
    add(OP_HOLD, 5, 16'h2305, 0, 0, 0);
    add(OP_STOP, 0, 16'h0000, 0, 0, 0);
    add(OP_KEY, 1, 16'h0001, 0, 0, 0);
    add(OP_KEY, 2, 16'h0012, 0, 0, 0);
    add(OP_KEY, 3, 16'h0123, 0, 0, 0);
    add(OP_KEY, 4, 16'h1234, 0, 0, 0);
    add(OP_KEY, 5, 16'h2345, 0, 0, 0);
    add(OP_KEY, 12, 16'h2345, 0, 0, 0);
    add(OP_STOP, 0, 16'h0000, 0, 0, 0);
    add(OP_START, 0, 16'h0030, 1, 0, 1);
    add(OP_TICK, 29, 16'h0001, 1, 0, 1);
    add(OP_TICK, 1, 16'h0000, 0, 1, 1);
    add(OP_STOP, 0, 16'h0000, 0, 0, 0);
    add(OP_KEY, 1, 16'h0001, 0, 0, 0);
    add(OP_KEY, 0, 16'h0010, 0, 0, 0);
    add(OP_KEY, 0, 16'h0100, 0, 0, 0);
    add(OP_START, 0, 16'h0100, 1, 0, 1);
    add(OP_TICK, 1, 16'h0059, 1, 0, 1);
    add(OP_STOP, 0, 16'h0059, 0, 0, 1);
    add(OP_STOP, 0, 16'h0000, 0, 0, 0);
    add(OP_KEY, 9, 16'h0009, 0, 0, 0);
    add(OP_KEY, 9, 16'h0099, 0, 0, 0);
    add(OP_START, 0, 16'h0099, 1, 0, 1);
    add(OP_TICK, 1, 16'h0098, 1, 0, 1);
    add(OP_TICK, 8, 16'h0090, 1, 0, 1);
    add(OP_TICK, 1, 16'h0089, 1, 0, 1);
    add(OP_STOP, 0, 16'h0089, 0, 0, 1);
    add(OP_STOP, 0, 16'h0000, 0, 0, 0);
    add(OP_KEY, 4, 16'h0004, 0, 0, 0);
    add(OP_KEY, 2, 16'h0042, 0, 0, 0);
    add(OP_START, 0, 16'h0042, 1, 0, 1);
    add(OP_DOOR, 0, 16'h0042, 0, 0, 1);
    add(OP_TICK, 3, 16'h0042, 0, 0, 1);
    add(OP_DOOR, 1, 16'h0042, 0, 0, 1);
    add(OP_START, 0, 16'h0042, 1, 0, 1);
    add(OP_TICK, 1, 16'h0041, 1, 0, 1);
    add(OP_DOOR, 0, 16'h0041, 0, 0, 1);
    add(OP_STOP, 0, 16'h0000, 0, 0, 0);
    add(OP_KEY, 3, 16'h0003, 0, 0, 0);
    add(OP_START, 0, 16'h0003, 0, 0, 0);
    add(OP_DOOR, 1, 16'h0003, 0, 0, 0);
    add(OP_STOP, 0, 16'h0000, 0, 0, 0);
    add(OP_KEY, 5, 16'h0005, 0, 0, 0);
    add(OP_START, 0, 16'h0005, 1, 0, 1);
    add(OP_BOTH, 0, 16'h0005, 0, 0, 1);
    add(OP_STOP, 0, 16'h0000, 0, 0, 0);
    add(OP_KEY, 7, 16'h0007, 0, 0, 0);
    add(OP_START, 0, 16'h0007, 1, 0, 1);
    add(OP_RESET, 0, 16'h0000, 0, 0, 0);

    reset = 1'b1; loadn = 1'b1; startn = 1'b1; stopn = 1'b1;
    door_closed = 1'b1; tick_1hz = 1'b0; digit = 4'd0;
    cycles(3);
    reset = 1'b0;

    foreach (vecs[i]) begin
      run_op(vecs[i].op, vecs[i].arg);
      check($sformatf("step%0d time_bcd", i), time_bcd, vecs[i].t);
      check($sformatf("step%0d mag_on", i), {15'd0, mag_on}, {15'd0, vecs[i].mag});
      check($sformatf("step%0d done", i), {15'd0, done}, {15'd0, vecs[i].dn});
      check($sformatf("step%0d enablen", i), {15'd0, enablen}, {15'd0, vecs[i].en});
      reset = 1'b0;
    end

    // Randomized phase; begins with a reset so the model and the DUT share history.
    reset = 1'b1;
    @(posedge clk);
    model_step(1'b1, {door_closed, stopn, startn, loadn}, tick_1hz, digit);
    for (int n = 0; n < 4000; n++) begin
      @(negedge clk);
      check("rand time_bcd", time_bcd, to_bcd(m_val));
      check("rand mag_on", {15'd0, mag_on}, {15'd0, exp_mag});
      check("rand done", {15'd0, done}, {15'd0, m_st == M_DONE});
      check("rand enablen", {15'd0, enablen}, {15'd0, m_st != M_IDLE});
      reset    = ($urandom_range(0, 399) == 0);
      loadn    = ($urandom_range(0, 3) != 0);
      startn   = ($urandom_range(0, 7) != 0);
      stopn    = ($urandom_range(0, 39) != 0);
      tick_1hz = ($urandom_range(0, 2) == 0);
      digit    = 4'($urandom_range(0, 15));
      if ($urandom_range(0, 29) == 0) door_closed = ~door_closed;
      @(posedge clk);
      model_step(reset, {door_closed, stopn, startn, loadn}, tick_1hz, digit);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/microwave_controller.md
# microwave_controller

Sequencer for the microwave keypad datapath. It enables the keypad priority encoder, captures its `digit`/`loadn` strobes into a 4-digit BCD MM:SS time register, and runs a cook state machine. The state machine counts the time down on a 1 Hz tick and drives the magnetron and completion outputs. It sits between the encoder, the front-panel start/stop buttons, the door switch and the display/power stage.

## Interface

- `QUICK_START_BCD`, default 16'h0030, time loaded when start is pressed with an empty time register (00:30).
- `clk`  in  1  system clock.
- `reset`  in  1  synchronous, active-high.
- `digit`  in  4  BCD digit from the priority encoder.
- `loadn`  in  1  encoder strobe, active-low; a key press is a 1→0 transition.
- `startn`  in  1  start button, active-low.
- `stopn`  in  1  stop/clear button, active-low.
- `door_closed`  in  1  door switch level; 1 = closed.
- `tick_1hz`  in  1  one-`clk` pulse per second from the on-chip divider, same clock domain.
- `enablen`  out  1  encoder enable, active-low.
- `time_bcd`  out  16  {min_tens, min_units, sec_tens, sec_units}.
- `mag_on`  out  1  magnetron drive.
- `done`  out  1  cook-complete indicator.

## Operation

- `loadn`, `startn`, `stopn` and `door_closed` each pass through a 2-flop synchronizer plus one history flop.
  - Synchronizer reset values: 1 for the active-low inputs, 0 for `door_closed`.
  - A load, start or stop event is a single-cycle pulse on the falling edge of the synchronized signal. Holding a key yields exactly one event.
  - `door_closed` is used as a synchronized level.
- States: IDLE, COOK, PAUSE, DONE.
- IDLE: `enablen`=0, `mag_on`=0, `done`=0.
  - Load event with `digit` ≤ 9: shift left, `time_bcd` <= {`time_bcd`[11:0], `digit`}; the oldest digit is discarded. `digit` > 9 is ignored.
  - Stop event: `time_bcd` <= 0.
  - Start event with door closed: go to COOK. If `time_bcd` == 0, first load `QUICK_START_BCD`. Start with the door open is ignored.
- COOK: `enablen`=1, `mag_on`=1.
  - Each `tick_1hz` decrements the time in BCD.
    - If sec_units > 0, decrement sec_units.
    - Otherwise sec_units = 9; if sec_tens > 0, decrement sec_tens.
    - Otherwise sec_tens = 5 and the 2-digit minutes field decrements in BCD.
  - Entered seconds above 59 (e.g. 00:99) count down linearly without normalization.
  - A decrement that produces 0000 goes to DONE.
  - Stop event or door open: go to PAUSE.
- PAUSE: `enablen`=1, `mag_on`=0, time held.
  - Start event with door closed: go to COOK.
  - Stop event: go to IDLE with `time_bcd` <= 0.
- DONE: `enablen`=1, `mag_on`=0, `done`=1, `time_bcd`=0.
  - Start event, stop event or door open: go to IDLE, clearing `done`.
- Same-cycle priority:
  - stop > door open > start > tick > load.
  - In IDLE, a start and a load in the same cycle: start wins and the digit is dropped.
  - In COOK, door open or stop in the same cycle as a tick: the tick is ignored and the time is not decremented.
- Reset, including mid-cook: state IDLE, `time_bcd`=0, `mag_on`=0, `done`=0, `enablen`=0, synchronizers at their reset values.

## Timing

- All outputs are registered and update only on `clk` rising edges.
- Button/door latency: an input level first sampled at edge N produces the state/time update visible after edge N+2.
- `tick_1hz` is not synchronized. A tick asserted before edge N updates `time_bcd` after edge N.
- `mag_on` and `enablen` change in the same edge as the state transition. `mag_on` never asserts with the synchronized door open.
- A tick that brings the time to 0000 sets `done`=1 and `mag_on`=0 on that same edge.

## Structure

- Shared package `microwave_pkg`:
  - state enum `mw_state_t` {S_IDLE, S_COOK, S_PAUSE, S_DONE}
  - `bcd_t` (4-bit)
  - `BCD_ZERO` constant
  - default `QUICK_START_BCD` constant
- One combinational sub-module, `bcd_mmss_dec`: 16-bit MM:SS in, decremented value out plus a `zero_next` flag.
- Synchronizers are inline.

## Test plan

- Keys 1,2,3,0 via the encoder (after reset) → `time_bcd`=16'h1230. A key held 20 cycles adds one digit only.
- Five keys 1..5 → 16'h2345. Stop in IDLE → 16'h0000.
- Start with empty time, door closed → `time_bcd`=16'h0030, `mag_on`=1. 30 ticks → `done`=1, `mag_on`=0. Stop → IDLE, `done`=0.
- Time 16'h0100, start, one tick → 16'h0059. Time 16'h0099 → ticks give 0098 … 0090, 0089.
- Door opens mid-cook at 16'h0042 → PAUSE with `mag_on`=0 within 3 edges. Ticks hold 0042. Close and start → resumes. Stop in PAUSE → 0000.
- Stop and start asserted together in COOK → PAUSE. Reset asserted mid-cook → all outputs at reset values on the next edge.
